// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback arbiter's bus signals: the in-order pipe request,
// the long-latency unit offer, and the shared register-file write port with
// its bypass copy.
// master: the side that produces requests and sees the write port.
// slave:  the arbiter itself.
interface wb_port_arbiter_if;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;

    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;

    logic        regfile_w_en;
    logic [4:0]  regfile_w_reg;
    logic [31:0] regfile_w_data;
    logic [4:0]  wb_bp_reg;
    logic [31:0] wb_bp_val;

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output lu_valid, lu_rd, lu_data,
        input  pipe_stall, lu_ready,
        input  regfile_w_en, regfile_w_reg, regfile_w_data,
        input  wb_bp_reg, wb_bp_val
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  lu_valid, lu_rd, lu_data,
        output pipe_stall, lu_ready,
        output regfile_w_en, regfile_w_reg, regfile_w_data,
        output wb_bp_reg, wb_bp_val
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order pipeline and a long-latency unit. Long-latency results queue in a
// 2-entry FIFO; the pipe has priority. The write port and bypass outputs are
// registered (one cycle after the grant).
// Optional build macro WB_ARB_FAIRNESS_EN: after STARVE_LIMIT consecutive pipe
// wins over a waiting FIFO entry, the pipe is stalled for one cycle so the
// FIFO head can write. Without it the pipe always wins and is never stalled.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);

    // FIFO storage, pointers and occupancy
    logic [4:0]  fifo_rd   [2];
    logic [31:0] fifo_data [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        ready_en;

    // Arbitration signals
    logic        fifo_empty;
    logic        lu_ready;
    logic        pipe_stall;
    logic        push;
    logic        grant_pipe;
    logic        grant_fifo;
    logic [4:0]  win_rd;
    logic [31:0] win_data;

    // Registered write port
    logic        w_en;
    logic [4:0]  w_reg;
    logic [31:0] w_data;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("wb_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    assign fifo_empty = (count == 2'd0);

`ifdef WB_ARB_FAIRNESS_EN
    logic [3:0] starve_cnt;

    // Stall the pipe once the FIFO head has lost STARVE_LIMIT times in a row
    always_comb begin
        pipe_stall = bus.pipe_valid && !fifo_empty
                     && (starve_cnt == 4'(STARVE_LIMIT));
    end

    // Count consecutive pipe wins while an entry waits; any FIFO grant or an empty FIFO restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (grant_fifo || fifo_empty) begin
            starve_cnt <= 4'd0;
        end else if (grant_pipe) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign pipe_stall = 1'b0;
`endif

    // Ready depends only on registered occupancy, so a full FIFO refuses even while popping
    always_comb begin
        lu_ready   = ready_en && (count != 2'd2);
        push       = bus.lu_valid && lu_ready;
        grant_pipe = bus.pipe_valid && !pipe_stall;
        grant_fifo = !grant_pipe && !fifo_empty;
        win_rd     = grant_pipe ? bus.pipe_rd   : fifo_rd[rd_ptr];
        win_data   = grant_pipe ? bus.pipe_data : fifo_data[rd_ptr];
    end

    // FIFO control: pointers wrap naturally as single bits, ready comes up on the first edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (grant_fifo) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, grant_fifo})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage; contents are meaningless while count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.lu_rd;
            fifo_data[wr_ptr] <= bus.lu_data;
        end
    end

    // Register the winner onto the write port; rd=0 is consumed but never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en   <= 1'b0;
            w_reg  <= 5'd0;
            w_data <= 32'd0;
        end else begin
            w_en <= (grant_pipe || grant_fifo) && (win_rd != 5'd0);
            if (grant_pipe || grant_fifo) begin
                w_reg  <= win_rd;
                w_data <= win_data;
            end
        end
    end

    assign bus.lu_ready       = lu_ready;
    assign bus.pipe_stall     = pipe_stall;
    assign bus.regfile_w_en   = w_en;
    assign bus.regfile_w_reg  = w_reg;
    assign bus.regfile_w_data = w_data;
    assign bus.wb_bp_reg      = w_reg;
    assign bus.wb_bp_val      = w_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter. A queue-based reference model tracks the
// buffered long-latency results and the expected write port contents.
// Honours WB_ARB_FAIRNESS_EN the same way the design does.
module tb_wb_port_arbiter;
    localparam int LIMIT = 4;
`ifdef WB_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [36:0] mq[$];
    int          m_starve;
    bit          m_started;
    bit          m_en;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_ready;
    bit          m_stall;

    // Apply inputs and compute the expected combinational outputs
    task automatic drive(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bus.pipe_valid = pv;
        bus.pipe_rd    = prd;
        bus.pipe_data  = pd;
        bus.lu_valid   = lv;
        bus.lu_rd      = lrd;
        bus.lu_data    = ld;
        m_ready = m_started && (mq.size() < 2);
        m_stall = FAIR && pv && (mq.size() != 0) && (m_starve == LIMIT);
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Advance the model by one clock edge and wait until just after that edge
    task automatic tick();
        bit          gp;
        bit          gf;
        bit          was_empty;
        logic [36:0] h;
        was_empty = (mq.size() == 0);
        gp = bus.pipe_valid && !m_stall;
        gf = !gp && !was_empty;
        if (gp) begin
            m_en   = (bus.pipe_rd != 5'd0);
            m_reg  = bus.pipe_rd;
            m_data = bus.pipe_data;
        end else if (gf) begin
            h      = mq.pop_front();
            m_en   = (h[36:32] != 5'd0);
            m_reg  = h[36:32];
            m_data = h[31:0];
        end else begin
            m_en = 1'b0;
        end
        if (bus.lu_valid && m_ready) mq.push_back({bus.lu_rd, bus.lu_data});
        if (gf || was_empty) m_starve = 0;
        else if (gp) m_starve++;
        m_started = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mq.delete();
        m_starve  = 0;
        m_started = 1'b0;
        m_en      = 1'b0;
        m_reg     = 5'd0;
        m_data    = 32'd0;
        m_ready   = 1'b0;
        m_stall   = 1'b0;
    endtask

    // Full reset sequence ending one idle edge after release, so lu_ready is up
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_idle();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h5678);
        model_clear();
        @(posedge clk);
        #1;
        if (bus.regfile_w_en !== 1'b0) begin bad++; $display("FAIL reset_w_en got=%0h want=0", bus.regfile_w_en); end
        total++;
        if (bus.regfile_w_reg !== 5'd0) begin bad++; $display("FAIL reset_w_reg got=%0h want=0", bus.regfile_w_reg); end
        total++;
        if (bus.regfile_w_data !== 32'd0) begin bad++; $display("FAIL reset_w_data got=%0h want=0", bus.regfile_w_data); end
        total++;
        if (bus.wb_bp_reg !== 5'd0 || bus.wb_bp_val !== 32'd0) begin bad++; $display("FAIL reset_bp got=%0h/%0h want=0/0", bus.wb_bp_reg, bus.wb_bp_val); end
        total++;
        if (bus.lu_ready !== 1'b0) begin bad++; $display("FAIL reset_lu_ready got=%0h want=0", bus.lu_ready); end
        total++;
        if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_pipe_stall got=%0h want=0", bus.pipe_stall); end
        total++;
        rst_n = 1'b1;
        drive_idle();
        if (bus.lu_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%0h want=0", bus.lu_ready); end
        total++;
        tick();
        drive_idle();
        if (bus.lu_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%0h want=1", bus.lu_ready); end
        total++;
    endtask

    task automatic test_single_lu();
        do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive_idle();
        tick();
        if (bus.regfile_w_en !== 1'b1 || bus.regfile_w_reg !== 5'd5 || bus.regfile_w_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_lu_write got=%0h/%0h/%0h want=1/5/deadbeef", bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data);
        end
        total++;
        if (bus.wb_bp_reg !== 5'd5 || bus.wb_bp_val !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_lu_bypass got=%0h/%0h want=5/deadbeef", bus.wb_bp_reg, bus.wb_bp_val);
        end
        total++;
        tick();
        if (bus.regfile_w_en !== 1'b0) begin bad++; $display("FAIL single_lu_idle got=%0h want=0", bus.regfile_w_en); end
        total++;
    endtask

    task automatic test_pipe_priority();
        do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22);
        tick();
        drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        tick();
        if (bus.regfile_w_en !== 1'b1 || bus.regfile_w_reg !== 5'd3 || bus.regfile_w_data !== 32'h11) begin
            bad++; $display("FAIL prio_pipe_first got=%0h/%0h/%0h want=1/3/11", bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data);
        end
        total++;
        drive_idle();
        tick();
        if (bus.regfile_w_en !== 1'b1 || bus.regfile_w_reg !== 5'd7 || bus.regfile_w_data !== 32'h22) begin
            bad++; $display("FAIL prio_fifo_second got=%0h/%0h/%0h want=1/7/22", bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data);
        end
        total++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'(32'hA0 + i));
            else       drive_idle();
            if (i < 3) begin
                if (bus.lu_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%0h want=1", i, bus.lu_ready); end
                total++;
            end
            tick();
            if (i >= 1) begin
                if (bus.regfile_w_en !== 1'b1 || bus.regfile_w_reg !== 5'(10 + i - 1) || bus.regfile_w_data !== 32'(32'hA0 + i - 1)) begin
                    bad++; $display("FAIL b2b_write[%0d] got=%0h/%0h/%0h want=1/%0h/%0h", i, bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data, 10 + i - 1, 32'hA0 + i - 1);
                end
                total++;
            end
        end
        // Pipe continuously busy: two offers fill the FIFO and ready drops
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd1, 32'(i), 1'b1, 5'(20 + i), 32'(i));
            tick();
            if (bus.regfile_w_en !== 1'b1 || bus.regfile_w_reg !== 5'd1 || bus.regfile_w_data !== 32'(i)) begin
                bad++; $display("FAIL b2b_pipe_write[%0d] got=%0h/%0h/%0h want=1/1/%0h", i, bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data, i);
            end
            total++;
        end
        drive(1'b1, 5'd1, 32'd2, 1'b1, 5'd22, 32'd2);
        if (bus.lu_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%0h want=0", bus.lu_ready); end
        total++;
    endtask

    task automatic test_rd_zero();
        do_reset();
        drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
        if (bus.pipe_stall !== 1'b0) begin bad++; $display("FAIL rd0_pipe_stall got=%0h want=0", bus.pipe_stall); end
        total++;
        tick();
        if (bus.regfile_w_en !== 1'b0) begin bad++; $display("FAIL rd0_pipe_no_write got=%0h want=0", bus.regfile_w_en); end
        total++;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
        tick();
        drive_idle();
        tick();
        if (bus.regfile_w_en !== 1'b0) begin bad++; $display("FAIL rd0_lu_no_write got=%0h want=0", bus.regfile_w_en); end
        total++;
        // If the rd=0 entry had lingered, it would be ahead of this one
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        tick();
        drive_idle();
        tick();
        if (bus.regfile_w_en !== 1'b1 || bus.regfile_w_reg !== 5'd9 || bus.regfile_w_data !== 32'h99) begin
            bad++; $display("FAIL rd0_lu_popped got=%0h/%0h/%0h want=1/9/99", bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data);
        end
        total++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd2, 32'(i), 1'b1, 5'(12 + i), 32'(32'hC0 + i));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        if (bus.regfile_w_en !== 1'b0) begin bad++; $display("FAIL mid_reset_async got=%0h want=0", bus.regfile_w_en); end
        total++;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            tick();
            if (bus.regfile_w_en !== 1'b0) begin bad++; $display("FAIL mid_reset_discard[%0d] got=%0h/%0h want=0", i, bus.regfile_w_en, bus.regfile_w_reg); end
            total++;
        end
    endtask

`ifdef WB_ARB_FAIRNESS_EN
    task automatic test_fairness();
        bit want_stall;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 5'(1 + k), 32'(k), 1'b1, 5'(20 + (k % 10)), 32'(32'hF00 + k));
            want_stall = (k >= 5) && (k % 5 == 0);
            if (bus.pipe_stall !== want_stall) begin bad++; $display("FAIL fair_stall[%0d] got=%0h want=%0h", k, bus.pipe_stall, want_stall); end
            total++;
            tick();
            if (bus.regfile_w_en !== m_en || bus.regfile_w_reg !== m_reg || bus.regfile_w_data !== m_data) begin
                bad++; $display("FAIL fair_write[%0d] got=%0h/%0h/%0h want=%0h/%0h/%0h", k, bus.regfile_w_en, bus.regfile_w_reg, bus.regfile_w_data, m_en, m_reg, m_data);
            end
            total++;
        end
    endtask
`endif

    task automatic test_random();
        bit          pv;
        bit          lv;
        logic [4:0]  prd;
        logic [4:0]  lrd;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            pv  = ($urandom_range(0, 99) < 55);
            lv  = ($urandom_range(0, 99) < 60);
            prd = 5'($urandom_range(0, 7));
            lrd = 5'($urandom_range(0, 31));
            drive(pv, prd, $urandom, lv, lrd, $urandom);
            if (bus.lu_ready !== m_ready) begin bad++; $display("FAIL rand_ready[%0d] got=%0h want=%0h", k, bus.lu_ready, m_ready); end
            total++;
            if (bus.pipe_stall !== m_stall) begin bad++; $display("FAIL rand_stall[%0d] got=%0h want=%0h", k, bus.pipe_stall, m_stall); end
            total++;
            tick();
            if (bus.regfile_w_en !== m_en) begin bad++; $display("FAIL rand_w_en[%0d] got=%0h want=%0h", k, bus.regfile_w_en, m_en); end
            total++;
            if (bus.regfile_w_reg !== m_reg || bus.regfile_w_data !== m_data) begin
                bad++; $display("FAIL rand_w_port[%0d] got=%0h/%0h want=%0h/%0h", k, bus.regfile_w_reg, bus.regfile_w_data, m_reg, m_data);
            end
            total++;
            if (bus.wb_bp_reg !== m_reg || bus.wb_bp_val !== m_data) begin
                bad++; $display("FAIL rand_bypass[%0d] got=%0h/%0h want=%0h/%0h", k, bus.wb_bp_reg, bus.wb_bp_val, m_reg, m_data);
            end
            total++;
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        drive_idle();
        test_reset();
        test_single_lu();
        test_pipe_priority();
        test_back_to_back();
        test_rd_zero();
        test_reset_mid();
`ifdef WB_ARB_FAIRNESS_EN
        test_fairness();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a run that never completes
    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end
endmodule
